tick_calendar_converter: RTL and testbench

Converts a 64-bit free-running tick count (100 ticks per second, tick 0 = 1970-01-01 00:00:00.00 UTC, a Thursday) into time-of-day, calendar date and weekday fields for the display path. It sits directly downstream of the timer core and consumes its tick count. It also supplies the conversion that the clock-and-date view and the date-alarm compare logic read. Conversion is sequential, with a request/busy/done handshake and bounded latency.

---
 rtl/timer_pkg.sv | 57 +++++
 rtl/serial_divider.sv | 60 ++++++
 rtl/tick_calendar_converter.sv | 224 ++++++++++++++++++++++
 tb/tb_tick_calendar_converter.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared constants, types and calendar helpers for the tick-to-calendar conversion path.
package timer_pkg;

    localparam int unsigned EPOCH_YEAR      = 1970;
    localparam int unsigned TICK_HZ_DEFAULT = 100;
    localparam int unsigned DAYS_PER_QUAD   = 1461;
    localparam int unsigned DAYS_TO_2100    = 47482;

    typedef enum logic [2:0] {
        WD_SUN = 3'd0,
        WD_MON = 3'd1,
        WD_TUE = 3'd2,
        WD_WED = 3'd3,
        WD_THU = 3'd4,
        WD_FRI = 3'd5,
        WD_SAT = 3'd6
    } weekday_e;

    localparam weekday_e EPOCH_WEEKDAY = WD_THU;

    // Index 0 is January; February holds the common-year length.
    localparam logic [11:0][4:0] MONTH_DAYS = {
        5'd31, 5'd30, 5'd31, 5'd30, 5'd31, 5'd31,
        5'd30, 5'd31, 5'd30, 5'd31, 5'd28, 5'd31
    };

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LATCH,
        ST_DIV_CS,
        ST_DIV_S,
        ST_DIV_M,
        ST_DIV_H,
        ST_DIV_WD,
        ST_RANGE,
        ST_QUAD,
        ST_YEAR,
        ST_MONTH,
        ST_DONE
    } conv_state_e;

    function automatic logic [4:0] days_in_month(input logic [3:0] month, input logic leap);
        logic [4:0] len;
        len = 5'd31;
        for (int i = 0; i < 12; i++) begin
            if (month == 4'(i + 1)) len = MONTH_DAYS[i];
        end
        if (leap && (month == 4'd2)) len = 5'd29;
        return len;
    endfunction

    // Days from the epoch to January 1st of the given year, simple /4 leap rule.
    function automatic int unsigned days_before_year(input int unsigned year);
        return (year - EPOCH_YEAR) * 365 + ((year - 1) / 4 - (EPOCH_YEAR - 1) / 4);
    endfunction

endpackage

// File: rtl/serial_divider.sv
// Restoring divider: one load cycle, then one quotient bit per cycle, MSB first.
module serial_divider #(
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    output logic             o_done,
    output logic [WIDTH-1:0] o_quotient,
    output logic [WIDTH-1:0] o_remainder
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    logic [CNT_W-1:0] r_count;
    logic             r_active;
    logic [WIDTH-1:0] r_quot;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_divisor;
    logic [WIDTH:0]   w_shift;
    logic             w_fits;

    // Partial remainder is one bit wider so the shifted value never overflows.
    assign w_shift = {r_rem, r_quot[WIDTH-1]};
    assign w_fits  = (w_shift >= {1'b0, r_divisor});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count   <= '0;
            r_active  <= 1'b0;
            r_quot    <= '0;
            r_rem     <= '0;
            r_divisor <= '0;
            o_done    <= 1'b0;
        end else begin
            o_done <= 1'b0;
            if (i_start) begin
                r_quot    <= i_dividend;
                r_rem     <= '0;
                r_divisor <= i_divisor;
                r_count   <= CNT_W'(WIDTH);
                r_active  <= 1'b1;
            end else if (r_active) begin
                r_rem   <= w_fits ? WIDTH'(w_shift - {1'b0, r_divisor}) : w_shift[WIDTH-1:0];
                r_quot  <= {r_quot[WIDTH-2:0], w_fits};
                r_count <= r_count - CNT_W'(1);
                if (r_count == CNT_W'(1)) begin
                    r_active <= 1'b0;
                    o_done   <= 1'b1;
                end
            end
        end
    end

    assign o_quotient  = r_quot;
    assign o_remainder = r_rem;

endmodule

// File: rtl/tick_calendar_converter.sv
// Sequential conversion of a 64-bit tick count into time-of-day, weekday and calendar date.
module tick_calendar_converter
    import timer_pkg::*;
#(
    parameter int unsigned TICK_HZ  = TICK_HZ_DEFAULT,
    parameter int unsigned MAX_YEAR = 2099
) (
    input  logic        clockSignal,
    input  logic        resetSignal,
    input  logic [63:0] tickCount,
    input  logic        convertRequest,
    output logic        busy,
    output logic        done,
    output logic        rangeError,
    output logic [6:0]  millisecondsDisplay,
    output logic [5:0]  secondsDisplay,
    output logic [5:0]  timeInMinutesDisplay,
    output logic [4:0]  timeInHoursDisplay,
    output logic [5:0]  dayDisplay,
    output logic [5:0]  dateDisplay,
    output logic [3:0]  monthDisplay,
    output logic [13:0] yearDisplay
);

    // First unsupported day; 47482 (2100-01-01) for the default last year.
    localparam int unsigned DAY_LIMIT = (MAX_YEAR == 2099) ? DAYS_TO_2100
                                                           : days_before_year(MAX_YEAR + 1);

    conv_state_e r_state;
    conv_state_e w_state_nxt;

    logic [63:0] r_tick;
    logic [63:0] r_days;
    logic [6:0]  r_cs;
    logic [5:0]  r_sec;
    logic [5:0]  r_min;
    logic [4:0]  r_hr;
    logic [2:0]  r_wd;
    logic [15:0] r_doy;
    logic [13:0] r_year;
    logic [3:0]  r_month;

    logic        w_div_start;
    logic        w_div_done;
    logic [63:0] w_div_dividend;
    logic [63:0] w_div_divisor;
    logic [63:0] w_div_quot;
    logic [63:0] w_div_rem;

    logic        w_out_of_range;
    logic        w_leap;
    logic [8:0]  w_year_len;
    logic [4:0]  w_month_len;
    logic        w_quad_step;
    logic        w_year_step;
    logic        w_month_step;
    logic        w_load_fields;

    serial_divider #(
        .WIDTH(64)
    ) u_divider (
        .clk        (clockSignal),
        .rst        (resetSignal),
        .i_start    (w_div_start),
        .i_dividend (w_div_dividend),
        .i_divisor  (w_div_divisor),
        .o_done     (w_div_done),
        .o_quotient (w_div_quot),
        .o_remainder(w_div_rem)
    );

    assign w_out_of_range = (r_days >= 64'(DAY_LIMIT));
    assign w_leap         = (r_year[1:0] == 2'b00);
    assign w_year_len     = w_leap ? 9'd366 : 9'd365;
    assign w_month_len    = days_in_month(r_month, w_leap);
    assign w_quad_step    = (r_doy >= 16'(DAYS_PER_QUAD));
    assign w_year_step    = (r_doy >= 16'(w_year_len));
    assign w_month_step   = (r_doy >= 16'(w_month_len));

    // State register
    always_ff @(posedge clockSignal or posedge resetSignal) begin
        if (resetSignal) r_state <= ST_IDLE;
        else             r_state <= w_state_nxt;
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE:   if (convertRequest) w_state_nxt = ST_LATCH;
            ST_LATCH:  w_state_nxt = ST_DIV_CS;
            ST_DIV_CS: if (w_div_done) w_state_nxt = ST_DIV_S;
            ST_DIV_S:  if (w_div_done) w_state_nxt = ST_DIV_M;
            ST_DIV_M:  if (w_div_done) w_state_nxt = ST_DIV_H;
            ST_DIV_H:  if (w_div_done) w_state_nxt = ST_DIV_WD;
            ST_DIV_WD: if (w_div_done) w_state_nxt = ST_RANGE;
            ST_RANGE:  w_state_nxt = w_out_of_range ? ST_DONE : ST_QUAD;
            ST_QUAD:   if (!w_quad_step) w_state_nxt = ST_YEAR;
            ST_YEAR:   if (!w_year_step) w_state_nxt = ST_MONTH;
            ST_MONTH:  if (!w_month_step) w_state_nxt = ST_DONE;
            ST_DONE:   w_state_nxt = convertRequest ? ST_LATCH : ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // Divider chaining: each finished division launches the next from its quotient.
    always_comb begin
        w_div_start    = 1'b0;
        w_div_dividend = w_div_quot;
        w_div_divisor  = 64'd60;
        w_load_fields  = 1'b0;
        unique case (r_state)
            ST_LATCH: begin
                w_div_start    = 1'b1;
                w_div_dividend = r_tick;
                w_div_divisor  = 64'(TICK_HZ);
            end
            ST_DIV_CS: w_div_start = w_div_done;
            ST_DIV_S:  w_div_start = w_div_done;
            ST_DIV_M: begin
                w_div_start   = w_div_done;
                w_div_divisor = 64'd24;
            end
            ST_DIV_H: begin
                w_div_start    = w_div_done;
                w_div_dividend = w_div_quot + 64'(EPOCH_WEEKDAY);
                w_div_divisor  = 64'd7;
            end
            ST_MONTH: w_load_fields = !w_month_step;
            default: ;
        endcase
    end

    // Working registers: remainders, day count and the year/month walk.
    always_ff @(posedge clockSignal or posedge resetSignal) begin
        if (resetSignal) begin
            r_tick  <= '0;
            r_days  <= '0;
            r_cs    <= '0;
            r_sec   <= '0;
            r_min   <= '0;
            r_hr    <= '0;
            r_wd    <= '0;
            r_doy   <= '0;
            r_year  <= 14'(EPOCH_YEAR);
            r_month <= 4'd1;
        end else begin
            if (w_state_nxt == ST_LATCH) r_tick <= tickCount;
            unique case (r_state)
                ST_DIV_CS: if (w_div_done) r_cs  <= 7'(w_div_rem);
                ST_DIV_S:  if (w_div_done) r_sec <= 6'(w_div_rem);
                ST_DIV_M:  if (w_div_done) r_min <= 6'(w_div_rem);
                ST_DIV_H: begin
                    if (w_div_done) begin
                        r_hr   <= 5'(w_div_rem);
                        r_days <= w_div_quot;
                    end
                end
                ST_DIV_WD: if (w_div_done) r_wd <= 3'(w_div_rem);
                ST_RANGE: begin
                    r_doy   <= 16'(r_days);
                    r_year  <= 14'(EPOCH_YEAR);
                    r_month <= 4'd1;
                end
                ST_QUAD: begin
                    if (w_quad_step) begin
                        r_doy  <= r_doy - 16'(DAYS_PER_QUAD);
                        r_year <= r_year + 14'd4;
                    end
                end
                ST_YEAR: begin
                    if (w_year_step) begin
                        r_doy  <= r_doy - 16'(w_year_len);
                        r_year <= r_year + 14'd1;
                    end
                end
                ST_MONTH: begin
                    if (w_month_step) begin
                        r_doy   <= r_doy - 16'(w_month_len);
                        r_month <= r_month + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Handshake and range flag
    always_ff @(posedge clockSignal or posedge resetSignal) begin
        if (resetSignal) begin
            busy       <= 1'b0;
            done       <= 1'b0;
            rangeError <= 1'b0;
        end else begin
            busy <= (w_state_nxt != ST_IDLE) && (w_state_nxt != ST_DONE);
            done <= (w_state_nxt == ST_DONE);
            if (r_state == ST_RANGE) rangeError <= w_out_of_range;
        end
    end

    // Display fields move only on the edge into DONE, and not for out-of-range requests.
    always_ff @(posedge clockSignal or posedge resetSignal) begin
        if (resetSignal) begin
            millisecondsDisplay  <= '0;
            secondsDisplay       <= '0;
            timeInMinutesDisplay <= '0;
            timeInHoursDisplay   <= '0;
            dayDisplay           <= 6'(EPOCH_WEEKDAY);
            dateDisplay          <= 6'd1;
            monthDisplay         <= 4'd1;
            yearDisplay          <= 14'(EPOCH_YEAR);
        end else if (w_load_fields) begin
            millisecondsDisplay  <= r_cs;
            secondsDisplay       <= r_sec;
            timeInMinutesDisplay <= r_min;
            timeInHoursDisplay   <= r_hr;
            dayDisplay           <= 6'(r_wd);
            dateDisplay          <= 6'(r_doy + 16'd1);
            monthDisplay         <= r_month;
            yearDisplay          <= r_year;
        end
    end

endmodule

// File: tb/tb_tick_calendar_converter.sv
// Randomised and directed bench for tick_calendar_converter against a calendar model.
module tb_tick_calendar_converter;

    logic        clockSignal = 1'b0;
    logic        resetSignal;
    logic [63:0] tickCount;
    logic        convertRequest;
    logic        busy;
    logic        done;
    logic        rangeError;
    logic [6:0]  millisecondsDisplay;
    logic [5:0]  secondsDisplay;
    logic [5:0]  timeInMinutesDisplay;
    logic [4:0]  timeInHoursDisplay;
    logic [5:0]  dayDisplay;
    logic [5:0]  dateDisplay;
    logic [3:0]  monthDisplay;
    logic [13:0] yearDisplay;

    tick_calendar_converter dut (
        .clockSignal         (clockSignal),
        .resetSignal         (resetSignal),
        .tickCount           (tickCount),
        .convertRequest      (convertRequest),
        .busy                (busy),
        .done                (done),
        .rangeError          (rangeError),
        .millisecondsDisplay (millisecondsDisplay),
        .secondsDisplay      (secondsDisplay),
        .timeInMinutesDisplay(timeInMinutesDisplay),
        .timeInHoursDisplay  (timeInHoursDisplay),
        .dayDisplay          (dayDisplay),
        .dateDisplay         (dateDisplay),
        .monthDisplay        (monthDisplay),
        .yearDisplay         (yearDisplay)
    );

    always #5 clockSignal = ~clockSignal;

    typedef struct {
        int cs; int sec; int min; int hr; int wd;
        int date; int month; int year; bit err;
    } cal_t;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int month_len(input int mo, input int yr);
        case (mo)
            2:           return (yr % 4 == 0) ? 29 : 28;
            4, 6, 9, 11: return 30;
            default:     return 31;
        endcase
    endfunction

    // Plain calendar arithmetic: walk year by year, then month by month.
    function automatic cal_t model(input logic [63:0] t);
        cal_t f;
        logic [63:0] days;
        int rem;
        f.cs    = int'(t % 64'd100);
        f.sec   = int'((t / 64'd100) % 64'd60);
        f.min   = int'((t / 64'd6000) % 64'd60);
        f.hr    = int'((t / 64'd360000) % 64'd24);
        days    = t / 64'd8640000;
        f.wd    = int'((days + 64'd4) % 64'd7);
        f.err   = (days >= 64'd47482);
        f.year  = 1970;
        f.month = 1;
        f.date  = 1;
        if (!f.err) begin
            rem = int'(days);
            while (rem >= ((f.year % 4 == 0) ? 366 : 365)) begin
                rem -= (f.year % 4 == 0) ? 366 : 365;
                f.year++;
            end
            while (rem >= month_len(f.month, f.year)) begin
                rem -= month_len(f.month, f.year);
                f.month++;
            end
            f.date = rem + 1;
        end
        return f;
    endfunction

    function automatic cal_t epoch();
        cal_t f;
        f.cs = 0; f.sec = 0; f.min = 0; f.hr = 0; f.wd = 4;
        f.date = 1; f.month = 1; f.year = 1970; f.err = 0;
        return f;
    endfunction

    task automatic check_fields(input string tag, input cal_t e);
        chk({tag, "_cs"},    longint'(millisecondsDisplay),  e.cs);
        chk({tag, "_sec"},   longint'(secondsDisplay),       e.sec);
        chk({tag, "_min"},   longint'(timeInMinutesDisplay), e.min);
        chk({tag, "_hr"},    longint'(timeInHoursDisplay),   e.hr);
        chk({tag, "_wd"},    longint'(dayDisplay),           e.wd);
        chk({tag, "_date"},  longint'(dateDisplay),          e.date);
        chk({tag, "_month"}, longint'(monthDisplay),         e.month);
        chk({tag, "_year"},  longint'(yearDisplay),          e.year);
    endtask

    // Per-cycle compare against the model, sampled on the falling edge.
    cal_t cur;
    cal_t pend;
    bit   pend_valid = 0;
    int   lat = 0;

    always @(negedge clockSignal) begin
        if (resetSignal) begin
            chk("reset_busy", longint'(busy), 0);
            chk("reset_done", longint'(done), 0);
            chk("reset_rangeError", longint'(rangeError), 0);
            cur = epoch();
            check_fields("reset", cur);
            pend_valid = 0;
            lat = 0;
        end else begin
            if (pend_valid) lat++;
            if (done) begin
                chk("done_busy_low", longint'(busy), 0);
                if (!pend_valid) begin
                    chk("unexpected_done", longint'(done), 0);
                end else begin
                    checks++;
                    if (lat > 400) begin
                        errors++;
                        $display("FAIL latency: got %0d cycles, expected <= 400", lat);
                    end
                    chk("rangeError", longint'(rangeError), longint'(pend.err));
                    if (!pend.err) cur = pend;
                    pend_valid = 0;
                end
            end else if (pend_valid) begin
                if (lat == 1) chk("busy_rise", longint'(busy), 1);
                if (lat > 450) begin
                    chk("done_timeout", longint'(done), 1);
                    pend_valid = 0;
                end
            end
            check_fields("field", cur);
            if (convertRequest && !busy) begin
                pend = model(tickCount);
                pend_valid = 1;
                lat = 0;
            end
        end
    end

    task automatic request(input logic [63:0] t);
        for (int i = 0; i < 600 && busy; i++) begin
            @(posedge clockSignal); #1;
        end
        tickCount      = t;
        convertRequest = 1'b1;
        @(posedge clockSignal); #1;
        convertRequest = 1'b0;
        tickCount      = {$urandom, $urandom};
    endtask

    task automatic wait_done();
        bit saw;
        saw = 0;
        for (int i = 0; i < 600 && !saw; i++) begin
            if (done) saw = 1;
            else begin
                @(posedge clockSignal); #1;
            end
        end
        if (!saw) chk("wait_done", longint'(done), 1);
    endtask

    task automatic convert(input logic [63:0] t);
        request(t);
        wait_done();
    endtask

    task automatic expect_cal(input string tag, input int y, input int mo, input int d,
                              input int wd, input int h, input int mi, input int s, input int cs);
        chk({tag, "_year"},  longint'(yearDisplay),          y);
        chk({tag, "_month"}, longint'(monthDisplay),         mo);
        chk({tag, "_date"},  longint'(dateDisplay),          d);
        chk({tag, "_wd"},    longint'(dayDisplay),           wd);
        chk({tag, "_hr"},    longint'(timeInHoursDisplay),   h);
        chk({tag, "_min"},   longint'(timeInMinutesDisplay), mi);
        chk({tag, "_sec"},   longint'(secondsDisplay),       s);
        chk({tag, "_cs"},    longint'(millisecondsDisplay),  cs);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got no finish, expected finish before 90000 cycles");
        $fatal(1, "watchdog");
    end

    initial begin
        cal_t m;
        logic [63:0] t;
        resetSignal    = 1'b1;
        convertRequest = 1'b0;
        tickCount      = '0;

        // Hand-computed values pinning the model itself.
        m = model(64'd95182560000);
        chk("model_leap_year", m.year, 2000);
        chk("model_leap_month", m.month, 2);
        chk("model_leap_date", m.date, 29);
        chk("model_leap_wd", m.wd, 2);
        chk("model_leap_hr", m.hr, 12);
        m = model(64'd410244480000);
        chk("model_range_err", longint'(m.err), 1);

        repeat (3) @(posedge clockSignal);
        #1 resetSignal = 1'b0;

        convert(64'd0);
        expect_cal("t0", 1970, 1, 1, 4, 0, 0, 0, 0);
        chk("t0_rangeError", longint'(rangeError), 0);
        convert(64'd8639999);
        expect_cal("t8639999", 1970, 1, 1, 4, 23, 59, 59, 99);
        convert(64'd8640000);
        expect_cal("t8640000", 1970, 1, 2, 5, 0, 0, 0, 0);
        convert(64'd95182560000);
        expect_cal("leapday", 2000, 2, 29, 2, 12, 0, 0, 0);
        // Request placed in the done cycle must be taken.
        convert(64'd95191200000);
        expect_cal("mar1", 2000, 3, 1, 3, 12, 0, 0, 0);
        convert(64'd410244479999);
        expect_cal("last", 2099, 12, 31, 4, 23, 59, 59, 99);
        convert(64'd410244480000);
        chk("range_flag", longint'(rangeError), 1);
        expect_cal("range_hold", 2099, 12, 31, 4, 23, 59, 59, 99);
        convert(64'd0);
        chk("range_clear", longint'(rangeError), 0);

        // A request while busy is ignored.
        request(64'd8639999);
        repeat (20) @(posedge clockSignal);
        #1;
        tickCount      = 64'd95182560000;
        convertRequest = 1'b1;
        @(posedge clockSignal); #1;
        convertRequest = 1'b0;
        wait_done();
        expect_cal("ignored", 1970, 1, 1, 4, 23, 59, 59, 99);
        repeat (450) @(posedge clockSignal);
        #1;

        for (int i = 0; i < 30; i++) begin
            if (i % 6 == 5) t = {$urandom, $urandom};
            else t = 64'($urandom_range(0, 47600)) * 64'd8640000 + 64'($urandom_range(0, 8639999));
            convert(t);
        end

        // Reset in the middle of a conversion.
        request(64'd95182560000);
        repeat (99) @(posedge clockSignal);
        #1 resetSignal = 1'b1;
        #1;
        check_fields("midreset", epoch());
        chk("midreset_busy", longint'(busy), 0);
        repeat (2) @(posedge clockSignal);
        #1 resetSignal = 1'b0;
        repeat (450) @(posedge clockSignal);
        #1;
        convert(64'd8640000);
        expect_cal("after_reset", 1970, 1, 2, 5, 0, 0, 0, 0);
        repeat (5) @(posedge clockSignal);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
